chunked_adder: RTL and testbench

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder.sv | 151 +++++++++++++++
 tb/tb_chunked_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle adder that sums WIDTH-bit operands CHUNK bits per clock
//
// Purpose:
//   Adds A + B + Cin over N = WIDTH/CHUNK clock cycles, one CHUNK-bit slice per
//   cycle, with the carry rippling between slices through a register. The
//   result (S, Cout, V) is registered and only changes on the edge that
//   finishes the last slice.
//
// Parameters:
//   WIDTH  operand/sum width in bits (default 8)
//   CHUNK  bits added per cycle (default 4); WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk    in   1      sole clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request a new addition (accepted in IDLE or DONE)
//   A      in   WIDTH  operand A, latched on acceptance
//   B      in   WIDTH  operand B, latched on acceptance
//   Cin    in   1      carry-in, latched on acceptance
//   S      out  WIDTH  sum of the last completed addition
//   Cout   out  1      carry-out of the last completed addition
//   V      out  1      two's-complement overflow of the last completed addition
//   busy   out  1      high while slices are being added (RUN)
//   done   out  1      one-cycle pulse after S/Cout/V were updated (DONE)

module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    // Keep the counter at least one bit wide so the single-chunk case still elaborates.
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;       // latched A, shifted right one chunk per RUN edge
    logic [WIDTH-1:0]  r_b;       // latched B, shifted right one chunk per RUN edge
    logic              r_carry;   // carry into the chunk being processed
    logic [KW-1:0]     r_k;       // index of the chunk being processed
    logic [WIDTH-1:0]  r_sum;     // partial sums, filled from the top down
    logic [WIDTH-1:0]  r_s;
    logic              r_cout;
    logic              r_v;
    logic              r_busy;
    logic              r_done;

    logic [CHUNK:0]    w_chunk_sum;
    logic [WIDTH-1:0]  w_chunk_ext;
    logic [WIDTH-1:0]  w_sum_next;
    logic              w_v;
    logic              w_last;

    // The current chunk always sits in the low CHUNK bits of the shifted operands.
    assign w_chunk_sum = {1'b0, r_a[CHUNK-1:0]}
                       + {1'b0, r_b[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, r_carry};

    // New partial sum enters at the top; after N shifts chunk 0 lands at bit 0.
    assign w_chunk_ext = WIDTH'(w_chunk_sum[CHUNK-1:0]);
    assign w_sum_next  = (r_sum >> CHUNK) | (w_chunk_ext << (WIDTH - CHUNK));

    // On the last chunk the operand MSBs are A[WIDTH-1]/B[WIDTH-1]; the carry
    // into the sum MSB is recovered as a ^ b ^ s at that bit.
    assign w_v = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk_sum[CHUNK-1] ^ w_chunk_sum[CHUNK];

    assign w_last = (r_k == K_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_sum   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_k     <= '0;
                        r_sum   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here.
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_chunk_sum[CHUNK];
                    r_sum   <= w_sum_next;
                    if (w_last) begin
                        r_s     <= w_sum_next;
                        r_cout  <= w_chunk_sum[CHUNK];
                        r_v     <= w_v;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
    assign V    = r_v;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - self-checking bench for chunked_adder (8/4 and 16/16 configurations)

module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        cin = 1'b0;
    logic [7:0]  s;
    logic        cout, v, busy, done;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic [15:0] s16;
    logic        cout16, v16, busy16, done16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .S     (s),
        .Cout  (cout),
        .V     (v),
        .busy  (busy),
        .done  (done)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .A     (a16),
        .B     (b16),
        .Cin   (cin16),
        .S     (s16),
        .Cout  (cout16),
        .V     (v16),
        .busy  (busy16),
        .done  (done16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {Cout,S} from plain integer addition; V from signed range check.
    task automatic run_add(input string tag, input bit w16, input logic [15:0] ia,
                           input logic [15:0] ib, input logic ic, input bit junk);
        logic [16:0] e;
        logic [15:0] e_s;
        logic        e_c;
        int          sv;
        logic        e_v;
        int          n_exp;
        logic [15:0] s_before;
        logic        c_before, v_before;
        int          n_busy;
        int          budget;
        bit          held;

        if (w16) begin
            e     = 17'(ia) + 17'(ib) + 17'(ic);
            e_s   = e[15:0];
            e_c   = e[16];
            sv    = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
            e_v   = (sv > 32767) || (sv < -32768);
            n_exp = 1;
        end else begin
            e     = 17'(ia[7:0]) + 17'(ib[7:0]) + 17'(ic);
            e_s   = {8'h00, e[7:0]};
            e_c   = e[8];
            sv    = int'($signed(ia[7:0])) + int'($signed(ib[7:0])) + int'(ic);
            e_v   = (sv > 127) || (sv < -128);
            n_exp = 2;
        end

        s_before = w16 ? s16 : 16'(s);
        c_before = w16 ? cout16 : cout;
        v_before = w16 ? v16 : v;

        if (w16) begin a16 = ia; b16 = ib; cin16 = ic; start16 = 1'b1; end
        else     begin a = ia[7:0]; b = ib[7:0]; cin = ic; start = 1'b1; end
        @(posedge clk); #1;
        // Scramble operands after acceptance; they must not affect the result.
        start = 1'b0; start16 = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);

        n_busy = 0;
        budget = 0;
        held   = 1'b1;
        while (!(w16 ? done16 : done) && budget < 20) begin
            if (w16 ? busy16 : busy) n_busy++;
            if ((w16 ? s16 : 16'(s)) !== s_before || (w16 ? cout16 : cout) !== c_before ||
                (w16 ? v16 : v) !== v_before)
                held = 1'b0;
            if (junk && budget == 0) begin
                start = 1'b1; a = 8'h55; b = 8'h55;
            end
            @(posedge clk); #1;
            budget++;
            start = 1'b0;
        end

        check({tag, "_done_seen"}, 32'(w16 ? done16 : done), 32'd1);
        check({tag, "_S"},    32'(w16 ? s16 : 16'(s)), 32'(e_s));
        check({tag, "_Cout"}, 32'(w16 ? cout16 : cout), 32'(e_c));
        check({tag, "_V"},    32'(w16 ? v16 : v), 32'(e_v));
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(n_exp));
        check({tag, "_held_during_run"}, 32'(held), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 32'(w16 ? done16 : done), 32'd0);
        check({tag, "_idle_not_busy"}, 32'(w16 ? busy16 : busy), 32'd0);
    endtask

    initial begin
        bit          saw_done;
        logic [11:0] pat;
        logic [11:0] pat_exp;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset_S", 32'(s), 32'd0);
        check("reset_flags", {28'd0, cout, v, busy, done}, 32'd0);
        check("reset_S16", 32'(s16), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_add("basic_1p1",    1'b0, 16'h01, 16'h01, 1'b0, 1'b0);
        run_add("cross_chunk",  1'b0, 16'h0F, 16'h00, 1'b1, 1'b0);
        run_add("ff_ff",        1'b0, 16'hFF, 16'hFF, 1'b0, 1'b0);
        run_add("ovf_pos",      1'b0, 16'h7F, 16'h01, 1'b0, 1'b0);
        run_add("ovf_neg",      1'b0, 16'h80, 16'h80, 1'b0, 1'b0);
        run_add("start_in_run", 1'b0, 16'h10, 16'h20, 1'b0, 1'b1);

        // Reset in the middle of RUN.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrun_rst_S", 32'(s), 32'd0);
        check("midrun_rst_flags", {28'd0, cout, v, busy, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("midrun_no_done", 32'(saw_done), 32'd0);
        run_add("after_rst", 1'b0, 16'h03, 16'h04, 1'b0, 1'b0);

        // Start presented on the very first edge after reset release.
        rst = 1'b1;
        #1 rst = 1'b0;
        run_add("first_edge", 1'b0, 16'h21, 16'h42, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++)
            run_add("rand8", 1'b0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                    1'($urandom), 1'b0);

        // Single-chunk configuration.
        run_add("w16_ffff_1", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            run_add("rand16", 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        // Back-to-back with start held high: done every N+1 = 2 cycles.
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            pat[i]     = done16;
            pat_exp[i] = ((i % 2) == 0);
        end
        start16 = 1'b0;
        check("w16_b2b_pattern", 32'(pat), 32'(pat_exp));
        check("w16_b2b_S", 32'(s16), 32'h0000);
        check("w16_b2b_Cout", 32'(cout16), 32'd1);

        // Back-to-back on the 8/4 configuration: done every 3 cycles.
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            pat[i]     = done;
            pat_exp[i] = ((i % 3) == 1);
        end
        start = 1'b0;
        check("w8_b2b_pattern", 32'(pat), 32'(pat_exp));
        check("w8_b2b_S", 32'(s), 32'h10);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
